phase_sequencer: RTL and testbench
==================================

Name: phase_sequencer

Overview:
- Variable-length instruction phase controller; replaces the fixed 12-phase ring clock with a state machine on one clock.
- Issues single-cycle strobes to fetch, decode, selector, ALU/result-selector and EIP update. Only as many select/exec pairs as the decoded micro-op count are issued.
- Handles the fetch handshake with timeout, halt and run control, and counts retired instructions.

Parameters:
- MAX_OPS, 3, maximum micro-ops per instruction (select/exec pairs).
- FETCH_TIMEOUT, 16, cycles fetch_req may stay unacknowledged before an error halt.
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk, input, 1, system clock; all state changes on rising edge.
- reset, input, 1, asynchronous, active-low (0 = reset asserted).
- run, input, 1, level; 1 permits instruction issue.
- halt_req, input, 1, level; sampled only in RETIRE.
- fetch_ack, input, 1, fetch unit reports ope/eip valid.
- num_of_ope, input, 4, micro-op count from decoder.
- fetch_req, output, 1, held high in FETCH.
- decode_strobe, output, 1, one-cycle pulse in DECODE.
- sel_strobe, output, 1, one-cycle pulse per SELECT.
- exec_strobe, output, 1, one-cycle pulse per EXEC.
- op_index, output, 2, current micro-op number (0..MAX_OPS-1) during SELECT/EXEC.
- eip_strobe, output, 1, one-cycle pulse in RETIRE.
- busy, output, 1, high in every state except IDLE and HALT.
- halted, output, 1, high in HALT.
- err_bad_nops, output, 1, sticky; set when num_of_ope > MAX_OPS.
- err_fetch_timeout, output, 1, sticky; set on fetch timeout.
- instr_count, output, CNT_W, retired instructions; wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0; op count, timeout counter and instr_count cleared. Reset asserted mid-instruction aborts immediately. The first state after reset release is IDLE.
- States: IDLE, FETCH, DECODE, LATCH, SELECT, EXEC, RETIRE, HALT. Strobes are Moore outputs decoded from state.
- IDLE: go to FETCH when run=1; otherwise stay.
- FETCH:
  - fetch_req=1.
  - If fetch_ack=1 at the edge, go to DECODE and clear the timeout counter.
  - Otherwise increment the timeout counter. If it reaches FETCH_TIMEOUT-1 without ack, set err_fetch_timeout and go to HALT.
  - An ack in the same cycle as the limit wins; no error is raised.
- DECODE: decode_strobe=1 for one cycle; then go to LATCH.
- LATCH: no strobes; register num_of_ope at the edge.
  - 0: go directly to RETIRE (no-op instruction).
  - 1..MAX_OPS: n = value; op_index=0; go to SELECT.
  - >MAX_OPS: set err_bad_nops; n = MAX_OPS; go to SELECT.
- SELECT: sel_strobe=1; then go to EXEC.
- EXEC: exec_strobe=1.
  - If op_index = n-1, go to RETIRE.
  - Otherwise increment op_index and go to SELECT.
- RETIRE:
  - eip_strobe=1; instr_count increments at the leaving edge.
  - halt_req=1: go to HALT (halt has priority over run).
  - Else run=1: go to FETCH.
  - Else: go to IDLE.
- HALT: halted=1; stay while run=1; go to IDLE when run=0. Error flags clear only on reset.
- Deasserting run mid-instruction has no effect until RETIRE; the instruction always completes.
- Latency with immediate ack: 4+2n cycles from entering FETCH to the cycle after RETIRE. n=0 gives 4 cycles.
- op_index holds its last value outside SELECT/EXEC and is reset to 0 in LATCH.

Decomposition:
- Shared package cpu_seq_pkg: state enum encodings, MAX_OPS default, op_index width constant, strobe bit positions.
- One natural sub-module: seq_timeout_counter (clear/enable/limit-reached) for the fetch timeout. The rest is a single FSM.

Test Plan:
- Reset and idle: reset=0 then 1, run=0 -> all outputs 0; state stays IDLE for 10 cycles; busy=0.
- One-op instruction: run=1, fetch_ack=1, num_of_ope=1 ->
  - fetch_req cycle 0, decode_strobe cycle 1, latch cycle 2, sel_strobe cycle 3, exec_strobe cycle 4, eip_strobe cycle 5;
  - instr_count=1 after cycle 5; next fetch_req at cycle 6.
- Three ops, then zero ops:
  - num_of_ope=3 -> op_index 0,1,2 on three sel/exec pairs; eip_strobe at cycle 9.
  - num_of_ope=0 -> eip_strobe at cycle 3; no sel/exec strobes.
- Bad count: num_of_ope=5 -> err_bad_nops=1 and sticky; exactly 3 sel/exec pairs issued; instr_count increments.
- Fetch handshake and timeout:
  - ack delayed 3 cycles -> fetch_req high 4 cycles; decode follows.
  - ack never arrives -> err_fetch_timeout=1 and halted=1 after 16 FETCH cycles; run=0 then returns to IDLE.
- Halt and reset abort:
  - halt_req=1 during an instruction -> completes through RETIRE, then halted=1 and no new fetch_req.
  - reset=0 during EXEC -> all outputs 0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/cpu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_seq_pkg
// Description : Shared definitions for the instruction phase sequencer:
//               state encodings, micro-op limits and strobe bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_seq_pkg;

  // Default number of select/exec pairs a single instruction may issue.
  localparam int c_max_ops_default = 3;

  // Width of the op_index output and of the decoder's micro-op count.
  localparam int c_op_w   = 2;
  localparam int c_nops_w = 4;

  // Bit positions inside the internal strobe vector.
  localparam int c_stb_fetch  = 0;
  localparam int c_stb_decode = 1;
  localparam int c_stb_sel    = 2;
  localparam int c_stb_exec   = 3;
  localparam int c_stb_eip    = 4;
  localparam int c_stb_w      = 5;

  // Instruction phases; the strobes are decoded from these one-to-one.
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LATCH  = 4'd3,
    S_SELECT = 4'd4,
    S_EXEC   = 4'd5,
    S_RETIRE = 4'd6,
    S_HALT   = 4'd7
  } seq_state_t;

  // The sequencer is busy whenever an instruction is in flight.
  function automatic logic state_is_busy(input seq_state_t s);
    return !((s == S_IDLE) || (s == S_HALT));
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module      : seq_timeout_counter
// Description : Up-counter with synchronous clear, used to bound how long a
//               fetch request may stay unacknowledged. o_limit_reached is
//               high while the count equals LIMIT-1.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_timeout_counter #(
  parameter int LIMIT = 16,
  parameter int WIDTH = (LIMIT > 2) ? $clog2(LIMIT) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_limit_reached
);

  localparam logic [WIDTH-1:0] c_last = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] r_count;
  logic             w_reached;

  assign w_reached       = (r_count == c_last);
  assign o_limit_reached = w_reached;

  // Count enabled cycles; clear has priority, and the count parks at the limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !w_reached) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : phase_sequencer
// Description : Variable-length instruction phase controller. Walks each
//               instruction through FETCH, DECODE, LATCH, a decoded number of
//               SELECT/EXEC pairs and RETIRE, issuing one-cycle strobes,
//               handling fetch timeout, halt/run control and retire counting.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int MAX_OPS       = c_max_ops_default,
  parameter int FETCH_TIMEOUT = 16,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             halt_req,
  input  logic             fetch_ack,
  input  logic [3:0]       num_of_ope,
  output logic             fetch_req,
  output logic             decode_strobe,
  output logic             sel_strobe,
  output logic             exec_strobe,
  output logic [1:0]       op_index,
  output logic             eip_strobe,
  output logic             busy,
  output logic             halted,
  output logic             err_bad_nops,
  output logic             err_fetch_timeout,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [c_nops_w-1:0] c_max_ops = c_nops_w'(MAX_OPS);

  seq_state_t            r_state;
  seq_state_t            w_next_state;
  logic [c_stb_w-1:0]    w_strobes;

  logic [c_nops_w-1:0]   r_nops;
  logic [c_op_w-1:0]     r_op_index;
  logic                  w_last_op;

  logic                  r_err_bad_nops;
  logic                  r_err_fetch_timeout;
  logic [CNT_W-1:0]      r_instr_count;

  logic                  w_timeout_clear;
  logic                  w_timeout_enable;
  logic                  w_timeout_hit;

  // The current pair is the last one once op_index reaches n-1.
  assign w_last_op = ({{(c_nops_w - c_op_w){1'b0}}, r_op_index} == (r_nops - c_nops_w'(1)));

  // The timeout count only runs while a fetch is outstanding.
  assign w_timeout_enable = (r_state == S_FETCH);
  assign w_timeout_clear  = (r_state != S_FETCH) || fetch_ack;

  seq_timeout_counter #(
    .LIMIT (FETCH_TIMEOUT)
  ) u_fetch_timeout (
    .clk             (clk),
    .reset           (reset),
    .i_clear         (w_timeout_clear),
    .i_enable        (w_timeout_enable),
    .o_limit_reached (w_timeout_hit)
  );

  // State register; asserting reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state selection and Moore strobe decode.
  always_comb begin
    w_next_state = r_state;
    w_strobes    = '0;
    case (r_state)
      S_IDLE: begin
        if (run) begin
          w_next_state = S_FETCH;
        end
      end
      S_FETCH: begin
        w_strobes[c_stb_fetch] = 1'b1;
        // An ack arriving on the limit cycle still wins over the timeout.
        if (fetch_ack) begin
          w_next_state = S_DECODE;
        end else if (w_timeout_hit) begin
          w_next_state = S_HALT;
        end
      end
      S_DECODE: begin
        w_strobes[c_stb_decode] = 1'b1;
        w_next_state            = S_LATCH;
      end
      S_LATCH: begin
        // A zero micro-op count is a no-op and goes straight to retire.
        if (num_of_ope == '0) begin
          w_next_state = S_RETIRE;
        end else begin
          w_next_state = S_SELECT;
        end
      end
      S_SELECT: begin
        w_strobes[c_stb_sel] = 1'b1;
        w_next_state         = S_EXEC;
      end
      S_EXEC: begin
        w_strobes[c_stb_exec] = 1'b1;
        if (w_last_op) begin
          w_next_state = S_RETIRE;
        end else begin
          w_next_state = S_SELECT;
        end
      end
      S_RETIRE: begin
        w_strobes[c_stb_eip] = 1'b1;
        // Halt outranks run; run is only looked at between instructions.
        if (halt_req) begin
          w_next_state = S_HALT;
        end else if (run) begin
          w_next_state = S_FETCH;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_HALT: begin
        if (!run) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Latch the micro-op count (clamped to MAX_OPS) and step op_index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_nops     <= '0;
      r_op_index <= '0;
    end else if (r_state == S_LATCH) begin
      r_op_index <= '0;
      if (num_of_ope > c_max_ops) begin
        r_nops <= c_max_ops;
      end else begin
        r_nops <= num_of_ope;
      end
    end else if ((r_state == S_EXEC) && !w_last_op) begin
      r_op_index <= r_op_index + c_op_w'(1);
    end
  end

  // Sticky error flags; only reset clears them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_bad_nops      <= 1'b0;
      r_err_fetch_timeout <= 1'b0;
    end else begin
      if ((r_state == S_LATCH) && (num_of_ope > c_max_ops)) begin
        r_err_bad_nops <= 1'b1;
      end
      if ((r_state == S_FETCH) && !fetch_ack && w_timeout_hit) begin
        r_err_fetch_timeout <= 1'b1;
      end
    end
  end

  // Retired-instruction counter, bumped on the edge that leaves RETIRE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr_count <= '0;
    end else if (r_state == S_RETIRE) begin
      r_instr_count <= r_instr_count + CNT_W'(1);
    end
  end

  assign fetch_req         = w_strobes[c_stb_fetch];
  assign decode_strobe     = w_strobes[c_stb_decode];
  assign sel_strobe        = w_strobes[c_stb_sel];
  assign exec_strobe       = w_strobes[c_stb_exec];
  assign eip_strobe        = w_strobes[c_stb_eip];
  assign op_index          = r_op_index;
  assign busy              = state_is_busy(r_state);
  assign halted            = (r_state == S_HALT);
  assign err_bad_nops      = r_err_bad_nops;
  assign err_fetch_timeout = r_err_fetch_timeout;
  assign instr_count       = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_phase_sequencer
// Description : Self-checking bench for phase_sequencer. A queue-based model
//               of the instruction phases is compared against the DUT every
//               cycle; directed scenarios pin the model with literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_sequencer;

  localparam int MAX_OPS       = 3;
  localparam int FETCH_TIMEOUT = 16;
  localparam int CNT_W         = 16;

  // Plan entry kinds (entry = kind*8 + micro-op number).
  localparam int K_DEC = 1;
  localparam int K_LAT = 2;
  localparam int K_SEL = 3;
  localparam int K_EXE = 4;
  localparam int K_RET = 5;

  localparam int M_IDLE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_ISSUE = 2;
  localparam int M_HALT  = 3;

  // Observation bit positions.
  localparam int B_FETCH = 0;
  localparam int B_DEC   = 1;
  localparam int B_SEL   = 2;
  localparam int B_EXEC  = 3;
  localparam int B_EIP   = 4;
  localparam int B_HALT  = 5;

  logic             clk        = 1'b0;
  logic             reset      = 1'b0;
  logic             run        = 1'b0;
  logic             halt_req   = 1'b0;
  logic             fetch_ack  = 1'b0;
  logic [3:0]       num_of_ope = 4'd0;
  logic             fetch_req, decode_strobe, sel_strobe, exec_strobe, eip_strobe;
  logic [1:0]       op_index;
  logic             busy, halted, err_bad_nops, err_fetch_timeout;
  logic [CNT_W-1:0] instr_count;

  int total = 0;
  int bad   = 0;

  phase_sequencer #(
    .MAX_OPS       (MAX_OPS),
    .FETCH_TIMEOUT (FETCH_TIMEOUT),
    .CNT_W         (CNT_W)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .run               (run),
    .halt_req          (halt_req),
    .fetch_ack         (fetch_ack),
    .num_of_ope        (num_of_ope),
    .fetch_req         (fetch_req),
    .decode_strobe     (decode_strobe),
    .sel_strobe        (sel_strobe),
    .exec_strobe       (exec_strobe),
    .op_index          (op_index),
    .eip_strobe        (eip_strobe),
    .busy              (busy),
    .halted            (halted),
    .err_bad_nops      (err_bad_nops),
    .err_fetch_timeout (err_fetch_timeout),
    .instr_count       (instr_count)
  );

  always #5 clk = ~clk;

  wire logic [26:0] dut_vec = {fetch_req, decode_strobe, sel_strobe, exec_strobe, eip_strobe,
                               busy, halted, err_bad_nops, err_fetch_timeout, op_index, instr_count};

  // ---------------- behavioural model ----------------
  int               m_mode = M_IDLE;
  int               plan[$];
  int               m_tc   = 0;
  logic             m_ebad = 1'b0;
  logic             m_eto  = 1'b0;
  logic [CNT_W-1:0] m_cnt  = '0;
  logic [1:0]       m_op   = 2'd0;

  task automatic model_reset();
    m_mode = M_IDLE;
    plan.delete();
    m_tc   = 0;
    m_ebad = 1'b0;
    m_eto  = 1'b0;
    m_cnt  = '0;
    m_op   = 2'd0;
  endtask

  task automatic model_step();
    int e, kind, idx, nn;
    case (m_mode)
      M_IDLE: if (run) begin m_mode = M_FETCH; m_tc = 0; end
      M_FETCH: begin
        if (fetch_ack) begin
          plan.push_back(K_DEC * 8);
          plan.push_back(K_LAT * 8);
          m_mode = M_ISSUE;
          m_tc   = 0;
        end else if (m_tc == FETCH_TIMEOUT - 1) begin
          m_eto  = 1'b1;
          m_mode = M_HALT;
          m_tc   = 0;
        end else begin
          m_tc++;
        end
      end
      M_ISSUE: begin
        e    = plan.pop_front();
        kind = e / 8;
        idx  = e % 8;
        if (kind == K_LAT) begin
          nn = int'(num_of_ope);
          if (nn > MAX_OPS) begin m_ebad = 1'b1; nn = MAX_OPS; end
          m_op = 2'd0;
          for (int i = 0; i < nn; i++) begin
            plan.push_back(K_SEL * 8 + i);
            plan.push_back(K_EXE * 8 + i);
          end
          plan.push_back(K_RET * 8);
        end else if (kind == K_EXE) begin
          if (plan.size() > 0 && (plan[0] / 8) != K_RET) m_op = 2'(idx + 1);
        end else if (kind == K_RET) begin
          m_cnt = m_cnt + 1'b1;
          if (halt_req)  m_mode = M_HALT;
          else if (run)  begin m_mode = M_FETCH; m_tc = 0; end
          else           m_mode = M_IDLE;
        end
      end
      M_HALT: if (!run) m_mode = M_IDLE;
      default: m_mode = M_IDLE;
    endcase
  endtask

  function automatic logic [26:0] model_vec();
    int front;
    front = 0;
    if (m_mode == M_ISSUE && plan.size() > 0) front = plan[0] / 8;
    return {m_mode == M_FETCH, front == K_DEC, front == K_SEL, front == K_EXE, front == K_RET,
            (m_mode == M_FETCH) || (m_mode == M_ISSUE), m_mode == M_HALT, m_ebad, m_eto, m_op, m_cnt};
  endfunction

  // Model advances on the same edges as the design, and resets with it.
  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else        model_step();
  end

  // ---------------- checking helpers ----------------
  task automatic tick();
    @(negedge clk);
    total++;
    if (dut_vec !== model_vec()) begin
      bad++;
      $display("FAIL model_cycle t=%0t got=%h want=%h", $time, dut_vec, model_vec());
    end
  endtask

  task automatic expect_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  logic [5:0]       obs     [0:39];
  logic [1:0]       op_obs  [0:39];
  logic [CNT_W-1:0] cnt_obs [0:39];

  // Start one instruction from IDLE and record ncyc cycles, cycle 0 = first FETCH cycle.
  task automatic capture(input int nope, input int ack_delay, input bit keep_run,
                         input bit hreq, input int ncyc);
    run        = 1'b1;
    num_of_ope = 4'(nope);
    fetch_ack  = (ack_delay == 0);
    halt_req   = hreq;
    for (int c = 0; c < ncyc; c++) begin
      tick();
      obs[c]     = {halted, eip_strobe, exec_strobe, sel_strobe, decode_strobe, fetch_req};
      op_obs[c]  = op_index;
      cnt_obs[c] = instr_count;
      if (!keep_run) run = 1'b0;
      fetch_ack = (c >= ack_delay);
    end
  endtask

  function automatic int first_at(input int b, input int from, input int n);
    for (int c = from; c < n; c++) if (obs[c][b]) return c;
    return -1;
  endfunction

  function automatic int count_bit(input int b, input int n);
    int k;
    k = 0;
    for (int c = 0; c < n; c++) if (obs[c][b]) k++;
    return k;
  endfunction

  task automatic wait_idle();
    bit ok;
    ok        = 1'b0;
    run       = 1'b0;
    halt_req  = 1'b0;
    fetch_ack = 1'b1;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (!busy && !halted) begin ok = 1'b1; break; end
    end
    expect_int("wait_idle", int'(ok), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit found;

    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (10) tick();
    expect_int("idle_outputs_zero", int'(dut_vec), 0);
    expect_int("idle_busy", int'(busy), 0);

    // One micro-op, run kept high so the next fetch follows retire.
    capture(1, 0, 1'b1, 1'b0, 8);
    expect_int("one_fetch_c0", first_at(B_FETCH, 0, 8), 0);
    expect_int("one_decode", first_at(B_DEC, 0, 8), 1);
    expect_int("one_sel", first_at(B_SEL, 0, 8), 3);
    expect_int("one_exec", first_at(B_EXEC, 0, 8), 4);
    expect_int("one_eip", first_at(B_EIP, 0, 8), 5);
    expect_int("one_cnt_before", int'(cnt_obs[5]), 0);
    expect_int("one_cnt_after", int'(cnt_obs[6]), 1);
    expect_int("one_next_fetch", first_at(B_FETCH, 1, 8), 6);
    wait_idle();

    // Three micro-ops.
    capture(3, 0, 1'b0, 1'b0, 12);
    expect_int("three_eip", first_at(B_EIP, 0, 12), 9);
    expect_int("three_sel_count", count_bit(B_SEL, 12), 3);
    expect_int("three_exec_count", count_bit(B_EXEC, 12), 3);
    expect_int("three_op0", int'(op_obs[3]), 0);
    expect_int("three_op1", int'(op_obs[5]), 1);
    expect_int("three_op2", int'(op_obs[8]), 2);
    expect_int("three_no_refetch", first_at(B_FETCH, 1, 12), -1);
    wait_idle();

    // Zero micro-ops.
    capture(0, 0, 1'b0, 1'b0, 6);
    expect_int("zero_eip", first_at(B_EIP, 0, 6), 3);
    expect_int("zero_sel_count", count_bit(B_SEL, 6), 0);
    expect_int("zero_exec_count", count_bit(B_EXEC, 6), 0);
    wait_idle();

    // Over-range count is clamped and flagged.
    capture(5, 0, 1'b0, 1'b0, 12);
    expect_int("bad_sel_count", count_bit(B_SEL, 12), 3);
    expect_int("bad_exec_count", count_bit(B_EXEC, 12), 3);
    expect_int("bad_eip", first_at(B_EIP, 0, 12), 9);
    expect_int("bad_retired", int'(cnt_obs[11] - cnt_obs[0]), 1);
    expect_int("bad_flag", int'(err_bad_nops), 1);
    wait_idle();
    capture(1, 0, 1'b0, 1'b0, 8);
    expect_int("bad_flag_sticky", int'(err_bad_nops), 1);
    wait_idle();

    // Ack delayed three cycles.
    capture(1, 3, 1'b0, 1'b0, 10);
    expect_int("delay_fetch_cycles", count_bit(B_FETCH, 10), 4);
    expect_int("delay_decode", first_at(B_DEC, 0, 10), 4);
    wait_idle();

    // Ack never arrives.
    capture(1, 1000, 1'b1, 1'b0, 20);
    expect_int("to_fetch_cycles", count_bit(B_FETCH, 20), 16);
    expect_int("to_halted_at", first_at(B_HALT, 0, 20), 16);
    expect_int("to_halt_holds", int'(obs[19][B_HALT]), 1);
    expect_int("to_flag", int'(err_fetch_timeout), 1);
    wait_idle();

    // Halt request honoured only at retire.
    capture(1, 0, 1'b1, 1'b1, 10);
    expect_int("halt_eip", first_at(B_EIP, 0, 10), 5);
    expect_int("halt_at", first_at(B_HALT, 0, 10), 6);
    expect_int("halt_no_fetch", first_at(B_FETCH, 1, 10), -1);
    expect_int("halt_holds", int'(obs[9][B_HALT]), 1);
    wait_idle();

    // Reset during EXEC clears everything before the next edge.
    run        = 1'b1;
    num_of_ope = 4'd3;
    fetch_ack  = 1'b1;
    found      = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      run = 1'b0;
      if (exec_strobe) begin found = 1'b1; break; end
    end
    expect_int("abort_reached_exec", int'(found), 1);
    #2 reset = 1'b0;
    #1 expect_int("abort_async_zero", int'(dut_vec), 0);
    tick();
    reset = 1'b1;
    repeat (3) tick();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      tick();
      run      = ($urandom_range(0, 9) < 8);
      halt_req = ($urandom_range(0, 15) == 0);
      if (((i / 400) % 4) == 3) fetch_ack = ($urandom_range(0, 9) == 0);
      else                      fetch_ack = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 9) < 7) num_of_ope = 4'($urandom_range(0, 3));
      else                          num_of_ope = 4'($urandom_range(4, 15));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
